lr_combine_top: RTL and testbench

//  Stereo matrix stage of the FM audio path: consumes the (L+R) sum stream A and the
//  (L-R) difference stream B from two input FIFOs. Produces left/right samples into two

---
 rtl/lr_pkg.sv | 56 +++++
 rtl/fifo.sv | 57 +++++
 rtl/lr_combine.sv | 136 +++++++++++++
 rtl/lr_combine_top.sv | 81 ++++++++
 tb/tb_lr_combine_top.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lr_pkg.sv
// ---------------------------------------------------------------------------
// lr_pkg
// Shared types and helpers for the stereo matrix stage.
//   lr_state_t : sequencing states of the combiner (read, calculate, write)
//   mode_t     : run-time matrix mode (stereo / mono / bypass)
//   out_of_range / sat_trunc : range handling of the one-bit-wider results.
//   The helpers work on a fixed MAX_DW+1 bit container so any sample width
//   up to MAX_DW can share them; callers sign-extend in and cast back out.
// ---------------------------------------------------------------------------
package lr_pkg;

  localparam int MAX_DW = 64;

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_CALC  = 2'd1,
    S_WRITE = 2'd2
  } lr_state_t;

  typedef enum logic [1:0] {
    MODE_STEREO = 2'b00,
    MODE_MONO   = 2'b01,
    MODE_BYPASS = 2'b10
  } mode_t;

  // Largest positive value representable in dw signed bits.
  function automatic logic signed [MAX_DW:0] max_of(input int unsigned dw);
    return ((MAX_DW+1)'(1) <<< (dw - 1)) - (MAX_DW+1)'(1);
  endfunction

  // Most negative value representable in dw signed bits.
  function automatic logic signed [MAX_DW:0] min_of(input int unsigned dw);
    return -((MAX_DW+1)'(1) <<< (dw - 1));
  endfunction

  // True when a widened result does not fit into dw signed bits.
  function automatic logic out_of_range(input logic signed [MAX_DW:0] val,
                                        input int unsigned dw);
    return (val > max_of(dw)) || (val < min_of(dw));
  endfunction

  // Reduce a widened result to dw bits: clamp when saturating, otherwise
  // simply keep the low bits (the caller truncates to dw).
  function automatic logic [MAX_DW-1:0] sat_trunc(input logic signed [MAX_DW:0] val,
                                                  input int unsigned dw,
                                                  input bit saturate);
    logic signed [MAX_DW:0] res;
    res = val;
    if (saturate) begin
      if (val > max_of(dw)) res = max_of(dw);
      else if (val < min_of(dw)) res = min_of(dw);
    end
    return res[MAX_DW-1:0];
  endfunction

endpackage

// File: rtl/fifo.sv
// ---------------------------------------------------------------------------
// fifo
// Synchronous single-clock FIFO with a registered read port: dout updates
// on the clock edge that samples rd_en, so data is valid the cycle after.
// Writes while full and reads while empty are ignored.
//   clock, reset (async, active-low) | wr_en, din, full | rd_en, dout, empty
// ---------------------------------------------------------------------------
module fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // Pointers carry one wrap bit so full and empty can be told apart.
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            do_wr;
  logic            do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr[ADDR_W-1:0]] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        dout   <= mem[rd_ptr[ADDR_W-1:0]];
      end
    end
  end

endmodule

// File: rtl/lr_combine.sv
// ---------------------------------------------------------------------------
// lr_combine
// Sequencer and arithmetic of the stereo matrix. Pops one sample from each
// input FIFO together, forms left/right according to the mode captured at
// pop time, and pushes both results together once both outputs have room.
//   clock, reset (async, active-low), mode
//   a_empty/a_rd_en/a_dout, b_empty/b_rd_en/b_dout : input FIFO side
//   l_full/l_wr_en/l_din, r_full/r_wr_en/r_din     : output FIFO side
//   overflow : sticky range-violation flag
// ---------------------------------------------------------------------------
module lr_combine
  import lr_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SATURATE   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic                  a_empty,
  output logic                  a_rd_en,
  input  logic [DATA_WIDTH-1:0] a_dout,
  input  logic                  b_empty,
  output logic                  b_rd_en,
  input  logic [DATA_WIDTH-1:0] b_dout,
  input  logic                  l_full,
  output logic                  l_wr_en,
  output logic [DATA_WIDTH-1:0] l_din,
  input  logic                  r_full,
  output logic                  r_wr_en,
  output logic [DATA_WIDTH-1:0] r_din,
  output logic                  overflow
);

  lr_state_t state;
  lr_state_t state_next;
  mode_t     mode_q;
  mode_t     mode_in;

  logic [DATA_WIDTH-1:0] l_q;
  logic [DATA_WIDTH-1:0] r_q;
  logic                  ovf_q;

  logic signed [DATA_WIDTH:0] a_ext;
  logic signed [DATA_WIDTH:0] b_ext;
  logic signed [DATA_WIDTH:0] l_wide;
  logic signed [DATA_WIDTH:0] r_wide;
  logic [DATA_WIDTH-1:0]      l_next;
  logic [DATA_WIDTH-1:0]      r_next;
  logic                       calc_ovf;

  // Encoding 11 is an alias of stereo; fold it so the latched mode is always legal.
  assign mode_in = (mode == 2'b11) ? MODE_STEREO : mode_t'(mode);

  // One extra bit of headroom makes sum and difference exact before range handling.
  assign a_ext = (DATA_WIDTH+1)'($signed(a_dout));
  assign b_ext = (DATA_WIDTH+1)'($signed(b_dout));

  always_comb begin
    l_wide = a_ext + b_ext;
    r_wide = a_ext - b_ext;
    case (mode_q)
      MODE_MONO: begin
        l_wide = a_ext;
        r_wide = a_ext;
      end
      MODE_BYPASS: begin
        l_wide = a_ext;
        r_wide = b_ext;
      end
      default: ;
    endcase
  end

  always_comb begin
    l_next   = DATA_WIDTH'(sat_trunc((MAX_DW+1)'(l_wide), DATA_WIDTH, SATURATE != 0));
    r_next   = DATA_WIDTH'(sat_trunc((MAX_DW+1)'(r_wide), DATA_WIDTH, SATURATE != 0));
    calc_ovf = out_of_range((MAX_DW+1)'(l_wide), DATA_WIDTH) ||
               out_of_range((MAX_DW+1)'(r_wide), DATA_WIDTH);
  end

  // Both inputs are popped in the same cycle and both outputs pushed in the
  // same cycle, so the L and R streams can never drift out of pairing.
  always_comb begin
    state_next = state;
    a_rd_en    = 1'b0;
    b_rd_en    = 1'b0;
    l_wr_en    = 1'b0;
    r_wr_en    = 1'b0;
    case (state)
      S_READ: begin
        if (!a_empty && !b_empty) begin
          a_rd_en    = 1'b1;
          b_rd_en    = 1'b1;
          state_next = S_CALC;
        end
      end
      S_CALC: begin
        state_next = S_WRITE;
      end
      S_WRITE: begin
        if (!l_full && !r_full) begin
          l_wr_en    = 1'b1;
          r_wr_en    = 1'b1;
          state_next = S_READ;
        end
      end
      default: state_next = S_READ;
    endcase
  end

  // Mode is captured only when a pair is popped so that a change arriving
  // mid-sample cannot split one pair across two modes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_READ;
      mode_q <= MODE_STEREO;
      l_q    <= '0;
      r_q    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_READ && a_rd_en) mode_q <= mode_in;
      if (state == S_CALC) begin
        l_q <= l_next;
        r_q <= r_next;
        if (calc_ovf) ovf_q <= 1'b1;
      end
    end
  end

  assign l_din    = l_q;
  assign r_din    = r_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/lr_combine_top.sv
// ---------------------------------------------------------------------------
// lr_combine_top
// Stereo matrix stage of the FM audio path: (L+R) stream A and (L-R) stream B
// in through two FIFOs, left/right samples out through two FIFOs.
//   clock, reset (async, active-low), mode (00/11 stereo, 01 mono, 10 bypass)
//   A_wr_en, A_din, A_full | B_wr_en, B_din, B_full : input FIFOs
//   L_rd_en, L_dout, L_empty | R_rd_en, R_dout, R_empty : output FIFOs
//   overflow : sticky, set on any clamped/wrapped result
// ---------------------------------------------------------------------------
module lr_combine_top
  import lr_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int FIFO_BUFFER_SIZE = 32,
  parameter int SATURATE         = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic                  A_wr_en,
  input  logic [DATA_WIDTH-1:0] A_din,
  output logic                  A_full,
  input  logic                  B_wr_en,
  input  logic [DATA_WIDTH-1:0] B_din,
  output logic                  B_full,
  input  logic                  L_rd_en,
  output logic [DATA_WIDTH-1:0] L_dout,
  output logic                  L_empty,
  input  logic                  R_rd_en,
  output logic [DATA_WIDTH-1:0] R_dout,
  output logic                  R_empty,
  output logic                  overflow
);

  logic                  a_rd_en;
  logic [DATA_WIDTH-1:0] a_dout;
  logic                  a_empty;
  logic                  b_rd_en;
  logic [DATA_WIDTH-1:0] b_dout;
  logic                  b_empty;
  logic                  l_wr_en;
  logic [DATA_WIDTH-1:0] l_din;
  logic                  l_full;
  logic                  r_wr_en;
  logic [DATA_WIDTH-1:0] r_din;
  logic                  r_full;

  fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_BUFFER_SIZE)) u_fifo_a (
    .clock(clock), .reset(reset),
    .wr_en(A_wr_en), .din(A_din), .full(A_full),
    .rd_en(a_rd_en), .dout(a_dout), .empty(a_empty)
  );

  fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_BUFFER_SIZE)) u_fifo_b (
    .clock(clock), .reset(reset),
    .wr_en(B_wr_en), .din(B_din), .full(B_full),
    .rd_en(b_rd_en), .dout(b_dout), .empty(b_empty)
  );

  fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_BUFFER_SIZE)) u_fifo_l (
    .clock(clock), .reset(reset),
    .wr_en(l_wr_en), .din(l_din), .full(l_full),
    .rd_en(L_rd_en), .dout(L_dout), .empty(L_empty)
  );

  fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_BUFFER_SIZE)) u_fifo_r (
    .clock(clock), .reset(reset),
    .wr_en(r_wr_en), .din(r_din), .full(r_full),
    .rd_en(R_rd_en), .dout(R_dout), .empty(R_empty)
  );

  lr_combine #(.DATA_WIDTH(DATA_WIDTH), .SATURATE(SATURATE)) u_combine (
    .clock(clock), .reset(reset), .mode(mode),
    .a_empty(a_empty), .a_rd_en(a_rd_en), .a_dout(a_dout),
    .b_empty(b_empty), .b_rd_en(b_rd_en), .b_dout(b_dout),
    .l_full(l_full), .l_wr_en(l_wr_en), .l_din(l_din),
    .r_full(r_full), .r_wr_en(r_wr_en), .r_din(r_din),
    .overflow(overflow)
  );

endmodule

// File: tb/tb_lr_combine_top.sv
// ---------------------------------------------------------------------------
// tb_lr_combine_top
// Drives a saturating and a wrapping instance with identical stimulus. A
// stream-level model turns every completed A/B pair into expected L/R words
// that are queued; a negedge monitor pops the output FIFOs and compares.
// ---------------------------------------------------------------------------
module tb_lr_combine_top;

  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic          A_wr_en, B_wr_en, L_rd_en, R_rd_en;
  logic [DW-1:0] A_din, B_din;

  logic          A_full, B_full, L_empty, R_empty, overflow;
  logic [DW-1:0] L_dout, R_dout;
  logic          A_full_w, B_full_w, L_empty_w, R_empty_w, overflow_w;
  logic [DW-1:0] L_dout_w, R_dout_w;

  lr_combine_top #(.DATA_WIDTH(DW), .FIFO_BUFFER_SIZE(32), .SATURATE(1)) dut (
    .clock(clock), .reset(reset), .mode(mode),
    .A_wr_en(A_wr_en), .A_din(A_din), .A_full(A_full),
    .B_wr_en(B_wr_en), .B_din(B_din), .B_full(B_full),
    .L_rd_en(L_rd_en), .L_dout(L_dout), .L_empty(L_empty),
    .R_rd_en(R_rd_en), .R_dout(R_dout), .R_empty(R_empty),
    .overflow(overflow)
  );

  lr_combine_top #(.DATA_WIDTH(DW), .FIFO_BUFFER_SIZE(32), .SATURATE(0)) dut_wrap (
    .clock(clock), .reset(reset), .mode(mode),
    .A_wr_en(A_wr_en), .A_din(A_din), .A_full(A_full_w),
    .B_wr_en(B_wr_en), .B_din(B_din), .B_full(B_full_w),
    .L_rd_en(L_rd_en), .L_dout(L_dout_w), .L_empty(L_empty_w),
    .R_rd_en(R_rd_en), .R_dout(R_dout_w), .R_empty(R_empty_w),
    .overflow(overflow_w)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] sat;
    logic [DW-1:0] wrap;
  } exp_t;

  exp_t   exp_l[$];
  exp_t   exp_r[$];
  longint qa[$];
  longint qb[$];
  bit     exp_ovf;
  int     n_checks;
  int     n_fail;
  bit     allow_l, allow_r;
  bit     l_pend, r_pend;
  exp_t   mon_l, mon_r;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Expected word for one channel: exact value reduced to the 32-bit range.
  function automatic exp_t model(input longint v);
    exp_t e;
    if (v > 64'sd2147483647) e.sat = 32'h7FFFFFFF;
    else if (v < -64'sd2147483648) e.sat = 32'h80000000;
    else e.sat = v[31:0];
    e.wrap = v[31:0];
    return e;
  endfunction

  function automatic bit oor(input longint v);
    return (v > 64'sd2147483647) || (v < -64'sd2147483648);
  endfunction

  // Pair up pending A and B samples in arrival order using the current mode.
  task automatic form_pairs();
    longint a, b, lv, rv;
    while (qa.size() > 0 && qb.size() > 0) begin
      a = qa.pop_front();
      b = qb.pop_front();
      case (mode)
        2'b01:   begin lv = a; rv = a; end
        2'b10:   begin lv = a; rv = b; end
        default: begin lv = a + b; rv = a - b; end
      endcase
      exp_l.push_back(model(lv));
      exp_r.push_back(model(rv));
      if (oor(lv) || oor(rv)) exp_ovf = 1'b1;
    end
  endtask

  task automatic applyStimulus(input bit do_a, input bit do_b,
                               input logic [DW-1:0] a, input logic [DW-1:0] b);
    int t = 0;
    while (((do_a && A_full) || (do_b && B_full)) && t < 2000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 2000) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL push_wait: input FIFO stayed full, required not full");
    end else begin
      A_wr_en = do_a;
      B_wr_en = do_b;
      A_din   = a;
      B_din   = b;
      if (do_a) qa.push_back(longint'($signed(a)));
      if (do_b) qb.push_back(longint'($signed(b)));
      form_pairs();
      @(negedge clock);
      A_wr_en = 1'b0;
      B_wr_en = 1'b0;
    end
  endtask

  // Wait for every expected pair to emerge, then confirm the outputs are
  // empty and the overflow flags match the model.
  task automatic checkOutput(input string tag);
    int t = 0;
    while ((exp_l.size() > 0 || exp_r.size() > 0) && t < 5000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 5000) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s_drain: %0d L / %0d R words outstanding, required 0",
               tag, exp_l.size(), exp_r.size());
    end
    repeat (10) @(negedge clock);
    check({tag, "_L_empty"}, 32'(L_empty), 32'(1'b1));
    check({tag, "_R_empty"}, 32'(R_empty), 32'(1'b1));
    check({tag, "_ovf_sat"}, 32'(overflow), 32'(exp_ovf));
    check({tag, "_ovf_wrap"}, 32'(overflow_w), 32'(exp_ovf));
  endtask

  function automatic logic [DW-1:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'h7FFFFFFF - $urandom_range(0, 3);
      2:       return 32'h80000000 + $urandom_range(0, 3);
      default: return $urandom_range(0, 1000);
    endcase
  endfunction

  // Monitor: compares the word popped on the previous edge, then decides
  // whether to pop again on the next one.
  always @(negedge clock) begin
    if (l_pend) begin
      if (exp_l.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL L_unexpected: got %h, required no output", L_dout);
      end else begin
        mon_l = exp_l.pop_front();
        check("L_sat", L_dout, mon_l.sat);
        check("L_wrap", L_dout_w, mon_l.wrap);
      end
    end
    if (r_pend) begin
      if (exp_r.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL R_unexpected: got %h, required no output", R_dout);
      end else begin
        mon_r = exp_r.pop_front();
        check("R_sat", R_dout, mon_r.sat);
        check("R_wrap", R_dout_w, mon_r.wrap);
      end
    end
    if (!reset) begin
      L_rd_en = 1'b0;
      R_rd_en = 1'b0;
    end else begin
      L_rd_en = allow_l && !L_empty && ($urandom_range(0, 3) != 0);
      R_rd_en = allow_r && !R_empty && ($urandom_range(0, 3) != 0);
    end
    l_pend = L_rd_en;
    r_pend = R_rd_en;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    mode    = 2'b00;
    A_wr_en = 1'b0;
    B_wr_en = 1'b0;
    A_din   = '0;
    B_din   = '0;
    L_rd_en = 1'b0;
    R_rd_en = 1'b0;
    allow_l = 1'b0;
    allow_r = 1'b0;
    exp_ovf = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_L_empty", 32'(L_empty), 32'(1'b1));
    check("rst_R_empty", 32'(R_empty), 32'(1'b1));
    check("rst_A_full", 32'(A_full), 32'(1'b0));
    check("rst_B_full", 32'(B_full), 32'(1'b0));
    check("rst_ovf", 32'(overflow), 32'(1'b0));
    reset   = 1'b1;
    allow_l = 1'b1;
    allow_r = 1'b1;
    @(negedge clock);

    // Basic stereo and the positive-overflow corner.
    applyStimulus(1, 1, 32'd100, 32'd30);
    checkOutput("stereo");
    applyStimulus(1, 1, 32'h7FFFFFFF, 32'd1);
    checkOutput("overflow");

    // Mono and bypass with a negative difference.
    mode = 2'b01;
    applyStimulus(1, 1, 32'd5, -32'sd3);
    checkOutput("mono");
    mode = 2'b10;
    applyStimulus(1, 1, 32'd5, -32'sd3);
    checkOutput("bypass");

    // Mode flipped one cycle after the pair was popped must not affect it.
    mode = 2'b00;
    applyStimulus(1, 1, 32'd20, 32'd7);
    @(negedge clock);
    mode = 2'b01;
    checkOutput("mode_flip");

    // Randomised blocks, each with its own mode, against random pops.
    for (int blk = 0; blk < 4; blk++) begin
      mode = 2'($urandom_range(0, 3));
      for (int i = 0; i < 20; i++) applyStimulus(1, 1, rand_val(), rand_val());
      checkOutput("random");
    end

    // Backpressure: nothing is popped until all 40 pairs are in flight.
    mode    = 2'b00;
    allow_l = 1'b0;
    allow_r = 1'b0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 40; i++) applyStimulus(1, 1, 32'(i * 7), 32'(i));
    repeat (300) @(negedge clock);
    check("bp_L_nonempty", 32'(L_empty), 32'(1'b0));
    check("bp_R_nonempty", 32'(R_empty), 32'(1'b0));
    check("bp_A_notfull", 32'(A_full), 32'(1'b0));
    allow_l = 1'b1;
    allow_r = 1'b1;
    checkOutput("backpressure");

    // Skewed arrival: A alone produces nothing.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 32'(1000 + i), '0);
    repeat (30) @(negedge clock);
    check("skew_L_empty", 32'(L_empty), 32'(1'b1));
    check("skew_R_empty", 32'(R_empty), 32'(1'b1));
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, '0, 32'(10 * i));
    checkOutput("skew");

    // Force overflow, then reset mid-calculation with data still queued.
    applyStimulus(1, 1, 32'h80000000, 32'd1);
    checkOutput("neg_overflow");
    allow_l = 1'b0;
    allow_r = 1'b0;
    repeat (3) @(negedge clock);
    applyStimulus(1, 1, 32'd11, 32'd22);
    applyStimulus(1, 1, 32'd33, 32'd44);
    reset = 1'b0;
    #1;
    check("arst_L_empty", 32'(L_empty), 32'(1'b1));
    check("arst_R_empty", 32'(R_empty), 32'(1'b1));
    check("arst_A_full", 32'(A_full), 32'(1'b0));
    check("arst_ovf_sat", 32'(overflow), 32'(1'b0));
    check("arst_ovf_wrap", 32'(overflow_w), 32'(1'b0));
    exp_l.delete();
    exp_r.delete();
    qa.delete();
    qb.delete();
    exp_ovf = 1'b0;
    @(negedge clock);
    reset   = 1'b1;
    allow_l = 1'b1;
    allow_r = 1'b1;
    repeat (30) @(negedge clock);
    check("post_rst_L_empty", 32'(L_empty), 32'(1'b1));
    applyStimulus(1, 1, -32'sd50, 32'd20);
    checkOutput("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
